// File: rtl/player_motion_pkg.sv
// Shared constants for the player controller and anything that decodes its
// state (e.g. the sprite renderer picking an animation by direction).
// Optional feature macro used by the player block: PLAYER_ACCEL_EN.
package player_motion_pkg;

    // Display and sprite geometry
    localparam int RES_H                = 640;
    localparam int SPRITE_WIDTH_SCALED  = 32;

    // Player defaults
    localparam int PLAYER_START_X       = 304;
    localparam int PLAYER_START_Y       = 440;
    localparam int PLAYER_STEP          = 2;
    localparam int PLAYER_FIRE_COOLDOWN = 30;

    // Movement FSM encodings, visible to the renderer
    localparam logic [1:0] PLAYER_ST_IDLE  = 2'd0;
    localparam logic [1:0] PLAYER_ST_LEFT  = 2'd1;
    localparam logic [1:0] PLAYER_ST_RIGHT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = PLAYER_ST_IDLE,
        ST_LEFT  = PLAYER_ST_LEFT,
        ST_RIGHT = PLAYER_ST_RIGHT
    } player_state_e;

    // True for the two states in which the player is travelling
    function automatic logic state_is_moving(input player_state_e st);
        return (st == ST_LEFT) || (st == ST_RIGHT);
    endfunction

endpackage

// File: rtl/player_motion_if.sv
// Button inputs and position/fire outputs of the player controller.
// master: game-side driver of the buttons; slave: the controller itself.
interface player_motion_if #(
    parameter int X_W = 10
);
    logic           frame;
    logic           enable;
    logic           left;
    logic           right;
    logic           fire;
    logic           shot_busy;
    logic [X_W-1:0] player_x;
    logic [X_W-1:0] player_y;
    logic           fire_req;
    logic           moving;

    modport master (
        output frame, enable, left, right, fire, shot_busy,
        input  player_x, player_y, fire_req, moving
    );

    modport slave (
        input  frame, enable, left, right, fire, shot_busy,
        output player_x, player_y, fire_req, moving
    );
endinterface

// File: rtl/player_fire_ctrl.sv
// Fire request generator: latches a button press between frames, rate-limits
// shots with a per-frame cooldown and emits a one-cycle launch pulse.
module player_fire_ctrl #(
    parameter int FIRE_COOLDOWN = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic frame,
    input  logic enable,
    input  logic fire,
    input  logic shot_busy,
    output logic fire_req
);
    // Width holds FIRE_COOLDOWN and stays at least one bit when it is 0
    localparam int              COOL_W = $clog2(FIRE_COOLDOWN + 2);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(FIRE_COOLDOWN);

    logic              latch_q, latch_d;
    logic [COOL_W-1:0] cool_q,  cool_d;
    logic              req_q,   req_d;
    logic              issue_s;

    // Next-state: latch, cooldown and pulse evaluated on the frame boundary
    always_comb begin
        latch_d = latch_q;
        cool_d  = cool_q;
        req_d   = 1'b0;
        issue_s = 1'b0;
        if (frame) begin
            issue_s = (latch_q | fire) && (cool_q == {COOL_W{1'b0}})
                      && !shot_busy && enable;
            if (issue_s) begin
                cool_d = COOL_LOAD;
            end else if (cool_q != {COOL_W{1'b0}}) begin
                cool_d = cool_q - {{(COOL_W-1){1'b0}}, 1'b1};
            end else begin
                cool_d = cool_q;
            end
            req_d   = issue_s;
            latch_d = 1'b0;
        end else if (!enable) begin
            latch_d = 1'b0;
        end else if (fire) begin
            latch_d = 1'b1;
        end else begin
            latch_d = latch_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_q <= 1'b0;
            cool_q  <= {COOL_W{1'b0}};
            req_q   <= 1'b0;
        end else begin
            latch_q <= latch_d;
            cool_q  <= cool_d;
            req_q   <= req_d;
        end
    end

    assign fire_req = req_q;

endmodule

// File: rtl/player_motion.sv
// Frame-synchronised player controller: direction FSM, velocity and clamped
// position datapath; fire handling lives in player_fire_ctrl.
// Optional feature: define PLAYER_ACCEL_EN for hold-to-accelerate velocity.
module player_motion
    import player_motion_pkg::*;
#(
    parameter int X_W           = 10,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = RES_H - SPRITE_WIDTH_SCALED,
    parameter int START_X       = PLAYER_START_X,
    parameter int START_Y       = PLAYER_START_Y,
    parameter int STEP          = PLAYER_STEP,
    parameter int MAX_STEP      = 8,
    parameter int ACCEL_FRAMES  = 4,
    parameter int FIRE_COOLDOWN = PLAYER_FIRE_COOLDOWN
) (
    input  logic           clk,
    input  logic           rst,
    player_motion_if.slave bus
);
    localparam int             XW1     = X_W + 1;
    localparam logic [X_W-1:0] STEP_V  = X_W'(STEP);
    localparam logic [X_W-1:0] XMIN_V  = X_W'(X_MIN);
    localparam logic [X_W-1:0] XMAX_V  = X_W'(X_MAX);
    localparam logic [XW1-1:0] XMIN_E  = XW1'(X_MIN);
    localparam logic [XW1-1:0] XMAX_E  = XW1'(X_MAX);

    player_state_e  state_q, state_d, next_s;
    logic [X_W-1:0] x_q, x_d;
    logic [X_W-1:0] y_q, y_d;
    logic [X_W-1:0] v_q, v_d;
    logic           moving_q, moving_d;
    logic [X_W-1:0] v_base_s;
    logic [XW1-1:0] ext_sum_s;

`ifdef PLAYER_ACCEL_EN
    localparam int                HOLD_W  = $clog2(ACCEL_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(ACCEL_FRAMES);
    localparam logic [XW1-1:0]    VMAX_E  = XW1'(MAX_STEP);
    logic [HOLD_W-1:0] hold_q, hold_d, hold_base_s, hold_inc_s;
    logic [XW1-1:0]    v_sum_s;
`else
    logic unused_cfg_s;
    assign unused_cfg_s = ^{32'(MAX_STEP), 32'(ACCEL_FRAMES)};
`endif

    // Next-state: direction, velocity and clamped position on each frame pulse
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        v_d       = v_q;
        moving_d  = moving_q;
        next_s    = ST_IDLE;
        v_base_s  = STEP_V;
        ext_sum_s = {XW1{1'b0}};
`ifdef PLAYER_ACCEL_EN
        hold_d      = hold_q;
        hold_base_s = {HOLD_W{1'b0}};
        hold_inc_s  = {HOLD_W{1'b0}};
        v_sum_s     = {XW1{1'b0}};
`endif
        if (!bus.enable) begin
            state_d  = ST_IDLE;
            v_d      = STEP_V;
            moving_d = 1'b0;
`ifdef PLAYER_ACCEL_EN
            hold_d   = {HOLD_W{1'b0}};
`endif
        end else if (bus.frame) begin
            case ({bus.left, bus.right})
                2'b10:   next_s = ST_LEFT;
                2'b01:   next_s = ST_RIGHT;
                default: next_s = ST_IDLE;
            endcase

            // Staying in the same direction keeps the built-up speed;
            // any change starts again from the base step
            if (next_s == state_q) begin
                v_base_s = v_q;
`ifdef PLAYER_ACCEL_EN
                hold_base_s = hold_q;
`endif
            end else begin
                v_base_s = STEP_V;
`ifdef PLAYER_ACCEL_EN
                hold_base_s = {HOLD_W{1'b0}};
`endif
            end

            // Extended-width arithmetic so the bounds never wrap
            case (next_s)
                ST_LEFT: begin
                    if ({1'b0, x_q} < (XMIN_E + {1'b0, v_base_s})) begin
                        x_d = XMIN_V;
                    end else begin
                        x_d = x_q - v_base_s;
                    end
                end
                ST_RIGHT: begin
                    ext_sum_s = {1'b0, x_q} + {1'b0, v_base_s};
                    if (ext_sum_s > XMAX_E) begin
                        x_d = XMAX_V;
                    end else begin
                        x_d = ext_sum_s[X_W-1:0];
                    end
                end
                default: x_d = x_q;
            endcase

`ifdef PLAYER_ACCEL_EN
            // The entry frame counts as the first held frame
            if (state_is_moving(next_s)) begin
                hold_inc_s = hold_base_s + {{(HOLD_W-1){1'b0}}, 1'b1};
                if (hold_inc_s >= HOLD_TOP) begin
                    hold_d  = {HOLD_W{1'b0}};
                    v_sum_s = {1'b0, v_base_s} + {1'b0, STEP_V};
                    if (v_sum_s > VMAX_E) begin
                        v_d = X_W'(MAX_STEP);
                    end else begin
                        v_d = v_sum_s[X_W-1:0];
                    end
                end else begin
                    hold_d = hold_inc_s;
                    v_d    = v_base_s;
                end
            end else begin
                hold_d = {HOLD_W{1'b0}};
                v_d    = STEP_V;
            end
`else
            v_d = STEP_V;
`endif
            state_d  = next_s;
            moving_d = state_is_moving(next_s);
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            x_q      <= X_W'(START_X);
            y_q      <= X_W'(START_Y);
            v_q      <= STEP_V;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            v_q      <= v_d;
            moving_q <= moving_d;
        end
    end

`ifdef PLAYER_ACCEL_EN
    // Hold counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= {HOLD_W{1'b0}};
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    player_fire_ctrl #(
        .FIRE_COOLDOWN (FIRE_COOLDOWN)
    ) u_fire (
        .clk       (clk),
        .rst       (rst),
        .frame     (bus.frame),
        .enable    (bus.enable),
        .fire      (bus.fire),
        .shot_busy (bus.shot_busy),
        .fire_req  (bus.fire_req)
    );

    assign bus.player_x = x_q;
    assign bus.player_y = y_q;
    assign bus.moving   = moving_q;

endmodule

// File: tb/tb_player_motion.sv
// Scoreboard bench for player_motion: stimulus pushes expected post-frame
// outputs, a monitor pops and compares one cycle after each frame or reset,
// and checks outputs hold steady on all other cycles.
module tb_player_motion;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    player_motion_if #(.X_W(10)) itf ();

    player_motion #(.MAX_STEP(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (itf)
    );

    typedef struct {
        int   x;
        logic mov;
        logic fr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic mon_en = 1'b0;
    int   last_x = 304;
    logic last_mov = 1'b0;
    int   cur_x = 304;
    logic mon_f, mon_r;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge
    always @(posedge clk) begin
        if (mon_en) begin
            mon_f = itf.frame;
            mon_r = rst;
            #1;
            if (mon_f || mon_r) begin
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("player_x", int'(itf.player_x), e.x);
                    chk("player_y", int'(itf.player_y), 440);
                    chk("moving", int'(itf.moving), int'(e.mov));
                    chk("fire_req", int'(itf.fire_req), int'(e.fr));
                    last_x   = e.x;
                    last_mov = e.mov;
                end
            end else begin
                chk("fire_req_one_cycle", int'(itf.fire_req), 0);
                chk("x_stable", int'(itf.player_x), last_x);
                chk("moving_stable", int'(itf.moving), int'(last_mov));
            end
        end
    end

    task automatic do_frame(input logic l, input logic r, input logic f,
                            input logic busy, input logic en,
                            input int ex, input logic em, input logic efr);
        @(negedge clk);
        itf.left      = l;
        itf.right     = r;
        itf.fire      = f;
        itf.shot_busy = busy;
        itf.enable    = en;
        itf.frame     = 1'b1;
        exp_q.push_back('{x: ex, mov: em, fr: efr});
        @(negedge clk);
        itf.frame  = 1'b0;
        itf.fire   = 1'b0;
        itf.enable = 1'b1;
        @(negedge clk);
    endtask

    // Reset coincident with a frame while right is held: reset must win
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        itf.frame = 1'b1;
        exp_q.push_back('{x: 304, mov: 1'b0, fr: 1'b0});
        @(negedge clk);
        rst       = 1'b0;
        itf.frame = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        itf.frame     = 1'b0;
        itf.enable    = 1'b1;
        itf.left      = 1'b0;
        itf.right     = 1'b0;
        itf.fire      = 1'b0;
        itf.shot_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Right held for three frames from the start position
        for (int i = 0; i < 3; i++) begin
            cur_x = cur_x + 2;
            do_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, cur_x, 1'b1, 1'b0);
        end

        // Reset while moving
        do_reset();
        cur_x = 304;

`ifndef PLAYER_ACCEL_EN
        // Run into the right bound and stay there
        for (int i = 0; i < 160; i++) begin
            cur_x = (cur_x + 2 > 608) ? 608 : cur_x + 2;
            do_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, cur_x, 1'b1, 1'b0);
        end
        // Run into the left bound and stay there
        for (int i = 0; i < 310; i++) begin
            cur_x = (cur_x < 2) ? 0 : cur_x - 2;
            do_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cur_x, 1'b1, 1'b0);
        end
`else
        // Hold-to-accelerate: steps 2,2,2,2,4,4,4,4,6,6
        begin
            int steps[10];
            steps = '{2, 2, 2, 2, 4, 4, 4, 4, 6, 6};
            for (int i = 0; i < 10; i++) begin
                cur_x = cur_x + steps[i];
                do_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, cur_x, 1'b1, 1'b0);
            end
        end
`endif

        // Both buttons: no movement, not moving
        do_frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, cur_x, 1'b0, 1'b0);
        do_frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, cur_x, 1'b0, 1'b0);

        // Right then reversal to left at the base step
        cur_x = cur_x + 2;
        do_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, cur_x, 1'b1, 1'b0);
        cur_x = cur_x - 2;
        do_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, cur_x, 1'b1, 1'b0);

        // Disabled on a frame: position frozen, forced idle
        do_frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, cur_x, 1'b0, 1'b0);
        do_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cur_x, 1'b0, 1'b0);

        // One-cycle fire between frames is latched for the next frame
        @(negedge clk);
        itf.fire = 1'b1;
        @(negedge clk);
        itf.fire = 1'b0;
        do_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cur_x, 1'b0, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            do_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cur_x, 1'b0, 1'b0);
        end
        // Frame 10: fire during cooldown is dropped
        do_frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, cur_x, 1'b0, 1'b0);
        for (int k = 11; k <= 30; k++) begin
            do_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cur_x, 1'b0, 1'b0);
        end
        // Frame 31: cooldown expired but bullet in flight
        do_frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, cur_x, 1'b0, 1'b0);
        // Frame 32: fire on the frame cycle itself launches
        do_frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, cur_x, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
